// File: rtl/alu_sequencer_if.sv
// Bus between the ALU sequencer and its environment: instruction handshake,
// external ALU operand/result path, retirement status and debug read port.
interface alu_sequencer_if;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_result;
  logic        done;
  logic [7:0]  result_out;
  logic        zero_flag;
  logic        err;
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;

  modport master (
    output instr_valid, instr, alu_result, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_opcode, done, result_out,
           zero_flag, err, dbg_data
  );

  modport slave (
    input  instr_valid, instr, alu_result, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_opcode, done, result_out,
           zero_flag, err, dbg_data
  );
endinterface

// File: rtl/alu_sequencer.sv
// Three-phase (IDLE/EXEC/WB) instruction sequencer driving an external
// combinational ALU and owning a 4 x 8-bit register file.
module alu_sequencer (
  input  logic           clk,
  input  logic           rst_n,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] regs [4];
  logic [3:0] op_q;
  logic [1:0] rd_q;
  logic [7:0] result_q;
  logic       accept;

  function automatic logic is_alu(input logic [2:0] func);
    return (func != 3'b000) && (func <= 3'd4);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op != 4'b0000) && !is_alu(op[2:0]);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Ready is masked by rst_n so nothing is offered while reset is held.
  always_comb begin
    next_state      = state;
    accept          = 1'b0;
    bus.instr_ready = 1'b0;
    bus.done        = 1'b0;
    bus.err         = 1'b0;
    case (state)
      IDLE: begin
        bus.instr_ready = rst_n;
        if (bus.instr_valid && rst_n) begin
          accept     = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: next_state = WB;
      WB: begin
        bus.done   = 1'b1;
        bus.err    = is_illegal(op_q);
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
      op_q           <= 4'h0;
      rd_q           <= 2'd0;
      result_q       <= 8'h00;
      bus.alu_a      <= 8'h00;
      bus.alu_b      <= 8'h00;
      bus.alu_opcode <= 4'h0;
      bus.result_out <= 8'h00;
      bus.zero_flag  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= bus.instr[15:12];
            rd_q      <= bus.instr[11:10];
            bus.alu_a <= regs[bus.instr[11:10]];
            bus.alu_b <= bus.instr[15] ? bus.instr[7:0] : regs[bus.instr[9:8]];
            bus.alu_opcode <= is_alu(bus.instr[14:12]) ? {1'b0, bus.instr[14:12]} : 4'h0;
          end
        end
        EXEC: begin
          result_q       <= bus.alu_result;
          bus.alu_a      <= 8'h00;
          bus.alu_b      <= 8'h00;
          bus.alu_opcode <= 4'h0;
        end
        // NOP and illegal ops retire without touching architectural state.
        WB: begin
          if (is_alu(op_q[2:0])) begin
            regs[rd_q]     <= result_q;
            bus.result_out <= result_q;
            bus.zero_flag  <= (result_q == 8'h00);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dbg_data = regs[bus.dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU on the operand bus.
module tb_alu_sequencer;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  logic [3:0] exec_opcode;
  logic [7:0] exec_a;
  logic [7:0] exec_b;
  logic       exec_ready;
  logic       exec_done;
  logic       wb_done;
  logic       wb_err;
  logic       wb_ready;
  logic       post_done;
  logic       post_err;
  logic       post_ready;

  alu_sequencer_if bus_if ();

  alu_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (bus_if.alu_opcode)
      4'd1:    bus_if.alu_result = bus_if.alu_a + bus_if.alu_b;
      4'd2:    bus_if.alu_result = bus_if.alu_a - bus_if.alu_b;
      4'd3:    bus_if.alu_result = bus_if.alu_a ^ bus_if.alu_b;
      4'd4:    bus_if.alu_result = bus_if.alu_b;
      default: bus_if.alu_result = 8'h00;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkReg(input logic [1:0] idx, input logic [7:0] expected, input string tag);
    bus_if.dbg_addr = idx;
    #1;
    checkOutput(tag, {8'h00, bus_if.dbg_data}, {8'h00, expected});
  endtask

  // Offers one instruction at a negedge and records EXEC/WB/next-IDLE views.
  task automatic applyStimulus(input logic [15:0] word);
    int waited = 0;
    while (!bus_if.instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_wait", {15'd0, bus_if.instr_ready}, 16'd1);
    bus_if.instr_valid = 1'b1;
    bus_if.instr       = word;
    @(negedge clk);
    bus_if.instr_valid = 1'b0;
    bus_if.instr       = 16'hFFFF;
    exec_opcode = bus_if.alu_opcode;
    exec_a      = bus_if.alu_a;
    exec_b      = bus_if.alu_b;
    exec_ready  = bus_if.instr_ready;
    exec_done   = bus_if.done;
    @(negedge clk);
    wb_done  = bus_if.done;
    wb_err   = bus_if.err;
    wb_ready = bus_if.instr_ready;
    @(negedge clk);
    post_done  = bus_if.done;
    post_err   = bus_if.err;
    post_ready = bus_if.instr_ready;
  endtask

  initial begin
    compared           = 0;
    mismatched         = 0;
    rst_n              = 1'b0;
    bus_if.instr_valid = 1'b0;
    bus_if.instr       = 16'h0000;
    bus_if.dbg_addr    = 2'd0;

    repeat (2) @(negedge clk);
    checkOutput("rst_ready",  {15'd0, bus_if.instr_ready}, 16'd0);
    checkOutput("rst_done",   {15'd0, bus_if.done}, 16'd0);
    checkOutput("rst_err",    {15'd0, bus_if.err}, 16'd0);
    checkOutput("rst_result", {8'h00, bus_if.result_out}, 16'h0000);
    checkOutput("rst_zero",   {15'd0, bus_if.zero_flag}, 16'd1);
    checkOutput("rst_alu",    {bus_if.alu_a, bus_if.alu_b}, 16'h0000);
    checkOutput("rst_opcode", {12'd0, bus_if.alu_opcode}, 16'h0000);
    for (int i = 0; i < 4; i++) checkReg(i[1:0], 8'h00, "rst_reg");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_rst", {15'd0, bus_if.instr_ready}, 16'd1);

    // MOV R1,#0x5A
    applyStimulus(16'hC45A);
    checkOutput("mov_exec_op",    {12'd0, exec_opcode}, 16'h0004);
    checkOutput("mov_exec_b",     {8'h00, exec_b}, 16'h005A);
    checkOutput("mov_exec_ready", {15'd0, exec_ready}, 16'd0);
    checkOutput("mov_exec_done",  {15'd0, exec_done}, 16'd0);
    checkOutput("mov_wb_done",    {15'd0, wb_done}, 16'd1);
    checkOutput("mov_wb_err",     {15'd0, wb_err}, 16'd0);
    checkOutput("mov_post_ready", {15'd0, post_ready}, 16'd1);
    checkOutput("mov_post_done",  {15'd0, post_done}, 16'd0);
    checkOutput("mov_result",     {8'h00, bus_if.result_out}, 16'h005A);
    checkOutput("mov_zero",       {15'd0, bus_if.zero_flag}, 16'd0);
    checkReg(2'd1, 8'h5A, "mov_r1");

    // XOR R1,R1
    applyStimulus(16'h3500);
    checkOutput("xor_exec_op", {12'd0, exec_opcode}, 16'h0003);
    checkOutput("xor_exec_ab", {exec_a, exec_b}, 16'h5A5A);
    checkOutput("xor_result",  {8'h00, bus_if.result_out}, 16'h0000);
    checkOutput("xor_zero",    {15'd0, bus_if.zero_flag}, 16'd1);
    checkReg(2'd1, 8'h00, "xor_r1");

    // R2 = 0xFF, then wrap up and back down with immediates
    applyStimulus(16'hC8FF);
    checkReg(2'd2, 8'hFF, "mov_r2");
    applyStimulus(16'h9801);
    checkOutput("add_exec_op", {12'd0, exec_opcode}, 16'h0001);
    checkReg(2'd2, 8'h00, "add_wrap_r2");
    checkOutput("add_zero", {15'd0, bus_if.zero_flag}, 16'd1);
    applyStimulus(16'hA801);
    checkReg(2'd2, 8'hFF, "sub_wrap_r2");
    checkOutput("sub_result", {8'h00, bus_if.result_out}, 16'h00FF);
    checkOutput("sub_zero",   {15'd0, bus_if.zero_flag}, 16'd0);

    // Register-sourced operands: MOV R1,R2 then ADD R1,R2
    applyStimulus(16'h4600);
    checkReg(2'd1, 8'hFF, "movr_r1");
    applyStimulus(16'h1600);
    checkOutput("addr_exec_ab", {exec_a, exec_b}, 16'hFFFF);
    checkReg(2'd1, 8'hFE, "addr_r1");

    // Illegal op 0x7 then NOP
    applyStimulus(16'h7000);
    checkOutput("ill_exec_op",  {12'd0, exec_opcode}, 16'h0000);
    checkOutput("ill_wb_done",  {15'd0, wb_done}, 16'd1);
    checkOutput("ill_wb_err",   {15'd0, wb_err}, 16'd1);
    checkOutput("ill_post_err", {15'd0, post_err}, 16'd0);
    checkOutput("ill_result",   {8'h00, bus_if.result_out}, 16'h00FE);
    checkOutput("ill_zero",     {15'd0, bus_if.zero_flag}, 16'd0);
    checkReg(2'd0, 8'h00, "ill_r0");
    checkReg(2'd2, 8'hFF, "ill_r2");
    applyStimulus(16'h0000);
    checkOutput("nop_wb_done", {15'd0, wb_done}, 16'd1);
    checkOutput("nop_wb_err",  {15'd0, wb_err}, 16'd0);
    checkOutput("nop_result",  {8'h00, bus_if.result_out}, 16'h00FE);
    checkReg(2'd0, 8'h00, "nop_r0");

    // Back-to-back: ADD R3,#1 held valid for nine cycles
    bus_if.instr_valid = 1'b1;
    bus_if.instr       = 16'h9C01;
    for (int i = 0; i < 9; i++) begin
      checkOutput("b2b_ready", {15'd0, bus_if.instr_ready}, {15'd0, (i % 3) == 0});
      checkOutput("b2b_done",  {15'd0, bus_if.done}, {15'd0, (i % 3) == 2});
      @(negedge clk);
    end
    bus_if.instr_valid = 1'b0;
    checkReg(2'd3, 8'h03, "b2b_r3");

    // Reset during EXEC of MOV R3,#0x11
    bus_if.instr_valid = 1'b1;
    bus_if.instr       = 16'hCC11;
    @(negedge clk);
    bus_if.instr_valid = 1'b0;
    checkOutput("abort_exec_op", {12'd0, bus_if.alu_opcode}, 16'h0004);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_done",  {15'd0, bus_if.done}, 16'd0);
    checkOutput("abort_ready", {15'd0, bus_if.instr_ready}, 16'd0);
    @(negedge clk);
    checkOutput("abort_done2", {15'd0, bus_if.done}, 16'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("abort_rel_ready", {15'd0, bus_if.instr_ready}, 16'd1);
    @(negedge clk);
    checkOutput("abort_rel_done", {15'd0, bus_if.done}, 16'd0);
    checkReg(2'd3, 8'h00, "abort_r3");
    checkOutput("abort_zero", {15'd0, bus_if.zero_flag}, 16'd1);

    applyStimulus(16'hCC22);
    checkOutput("after_wb_done", {15'd0, wb_done}, 16'd1);
    checkOutput("after_result",  {8'h00, bus_if.result_out}, 16'h0022);
    checkReg(2'd3, 8'h22, "after_r3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
